rr_arb_4req: RTL and testbench
==============================

// Module: rr_arb_4req
// PURPOSE
//  Round-robin arbiter sharing one resource among N requesters.
//  A rotating-priority encoder picks the winner. The choice is registered, and the grant is held while the owner keeps req high.
//  An optional hold limit preempts an owner that monopolises the resource.
//  Sits in front of a shared datapath port (bus, memory, encoder input mux) and drives its select lines.
// PARAMETERS
//  N        4  number of requesters (2..16)
//  IDW      2  width of gnt_id; must equal $clog2(N)
//  MAX_HOLD 8  max consecutive grant cycles while others wait; 0 = unlimited
// PORTS
//  clk        in   1    single clock, rising-edge
//  rst_n      in   1    reset, asynchronous, active-low
//  req        in   N    request per requester; level, held high while using the resource
//  gnt        out  N    one-hot grant, registered
//  gnt_id     out  IDW  binary index of the granted requester (0 when gnt_valid=0)
//  gnt_valid  out  1    |gnt
//  preempt    out  1    1-cycle pulse on the edge where the owner lost gnt by timeout
// BEHAVIOUR
//  Reset (rst_n=0, async): gnt=0, gnt_id=0, gnt_valid=0, preempt=0.
//   Internal: ptr=0, hold_cnt=0, state=IDLE. Takes effect immediately, also mid-grant.
//  Selection (combinational): scan req from index ptr upward, wrapping N-1 -> 0.
//   The first set bit wins. The current owner is excluded when preempting.
//  FSM states IDLE, BUSY:
//   IDLE: req==0 -> stay. req!=0 -> next edge: gnt=onehot(winner), hold_cnt=0, BUSY.
//   BUSY, req[owner]=1, no timeout: keep gnt, hold_cnt++ (saturating).
//   BUSY, req[owner]=0 (release): next edge:
//    - another req pending -> grant winner directly (no idle cycle);
//    - else gnt=0, go to IDLE.
//   BUSY, timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and another req pending.
//    - Next edge: gnt moves to the winner among the others; preempt=1 for that cycle.
//    - The old owner re-enters rotation normally.
//   Timeout with no other req pending: owner keeps gnt; hold_cnt saturates.
//  ptr: on every new grant to index k, ptr <= (k+1) mod N.
//   A newly granted requester therefore gets the lowest priority next time.
//  Latency: req rising -> gnt one edge later when the resource is free. Combinational req->gnt paths are forbidden.
//  Invariants: gnt is one-hot or zero; gnt_id/gnt_valid are consistent with gnt in the same cycle.
//  Simultaneous release and new req: treated as release. Winner is chosen from the req sampled at that edge.
//  hold_cnt resets to 0 on every new grant.
//  req from a non-owner while BUSY has no effect until release or timeout.
// TESTING
//  1. rst_n=0 with req=1111 -> gnt=0000, gnt_id=0, gnt_valid=0, preempt=0 throughout.
//  2. req=0100 at edge 0 -> gnt=0100, id=2 after edge 1; req drops at edge 5 -> gnt=0000 after edge 6.
//  3. MAX_HOLD=4, req=1111 held -> owners 0,1,2,3,0 for 4 cycles each; preempt pulses at each switch.
//  4. req=0011, owner 0 drops req -> gnt=0010 the very next edge, no gnt=0 gap cycle.
//  5. rst_n pulled low mid-grant (gnt=1000) -> gnt=0 immediately.
//     After release, req=1111 -> first grant is index 0.
//  6. MAX_HOLD=0, owner 1 holds req 100 cycles with req=1111 -> gnt stays 0010, preempt never asserts.

Source files
------------

// File: rtl/rr_arb_4req_if.sv
// rr_arb_4req_if: request/grant bundle between requesters and the round-robin arbiter.
//  req        requesters -> arbiter  one level request per requester
//  gnt        arbiter -> requesters  one-hot registered grant
//  gnt_id     arbiter -> requesters  binary index of the owner (0 when idle)
//  gnt_valid  arbiter -> requesters  |gnt
//  preempt    arbiter -> requesters  one-cycle pulse after a timeout handover
// Modports: master = requester side, slave = arbiter side.
interface rr_arb_4req_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           preempt;

    modport master (output req, input gnt, input gnt_id, input gnt_valid, input preempt);
    modport slave  (input req, output gnt, output gnt_id, output gnt_valid, output preempt);
endinterface

// File: rtl/rr_arb_4req.sv
// rr_arb_4req: round-robin arbiter with registered grant, grant hold while the
// owner keeps req high, and an optional hold limit that hands the resource to
// a waiting requester after MAX_HOLD consecutive owner cycles.
// Ports:
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset
//  bus    rr_arb_4req_if.slave (req in; gnt, gnt_id, gnt_valid, preempt out)
// Parameters: N requesters (2..16), IDW = $clog2(N), MAX_HOLD (0 = unlimited).
module rr_arb_4req #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb_4req_if.slave  bus
);

    // Counter only needs to reach MAX_HOLD-1; it saturates there.
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_SAT =
        HW'((MAX_HOLD == 0) ? ((2 ** HW) - 1) : (MAX_HOLD - 1));

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   gnt_reg, gnt_next;
    logic [IDW-1:0] id_reg, id_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic [HW-1:0]  hold_reg, hold_next;
    logic           preempt_reg, preempt_next;

    logic [N-1:0]   cand;
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [N-1:0]   win_onehot;
    logic [IDW-1:0] ptr_after_win;
    logic           owner_req;
    logic           timeout;
    logic           do_grant;

    // The current owner never competes against itself: while it holds, only
    // the others are candidates (used for preemption); after release its req
    // bit is already 0, and in IDLE gnt_reg is 0, so this mask is uniform.
    assign cand      = bus.req & ~gnt_reg;
    assign owner_req = |(bus.req & gnt_reg);
    assign timeout   = (MAX_HOLD != 0) && (hold_reg == HOLD_SAT);

    // Rotating-priority scan starting at ptr_reg, wrapping N-1 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(ptr_reg) + i;
            if (j >= N) j = j - N;
            if (!win_found && cand[j]) begin
                win_found = 1'b1;
                win_idx   = IDW'(j);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == IDW'(gi));
        end
    endgenerate

    // A fresh winner drops to lowest priority for the next arbitration.
    assign ptr_after_win = (int'(win_idx) == N - 1) ? '0 : IDW'(int'(win_idx) + 1);

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        id_next      = id_reg;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;
        preempt_next = 1'b0;
        do_grant     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (win_found) do_grant = 1'b1;
            end
            BUSY: begin
                if (!owner_req) begin
                    // Release: hand over directly if anyone waits, no idle gap.
                    if (win_found) begin
                        do_grant = 1'b1;
                    end else begin
                        gnt_next   = '0;
                        id_next    = '0;
                        state_next = IDLE;
                    end
                end else if (timeout && win_found) begin
                    do_grant     = 1'b1;
                    preempt_next = 1'b1;
                end else if (hold_reg != HOLD_SAT) begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (do_grant) begin
            gnt_next   = win_onehot;
            id_next    = win_idx;
            ptr_next   = ptr_after_win;
            hold_next  = '0;
            state_next = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            id_reg      <= '0;
            ptr_reg     <= '0;
            hold_reg    <= '0;
            preempt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            id_reg      <= id_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            preempt_reg <= preempt_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_id    = id_reg;
    assign bus.gnt_valid = |gnt_reg;
    assign bus.preempt   = preempt_reg;

endmodule

// File: tb/tb_rr_arb_4req.sv
// Directed bench for rr_arb_4req: three instances (MAX_HOLD = 8, 4, 0) sharing
// clock and reset; a vector table drives the default instance, and short
// hand-written sequences cover timeout rotation, unlimited hold and async reset.
module tb_rr_arb_4req;

    logic clk;
    logic rst_n;

    rr_arb_4req_if #(.N(4), .IDW(2)) bus_a ();
    rr_arb_4req_if #(.N(4), .IDW(2)) bus_b ();
    rr_arb_4req_if #(.N(4), .IDW(2)) bus_c ();

    rr_arb_4req #(.N(4), .IDW(2), .MAX_HOLD(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    rr_arb_4req #(.N(4), .IDW(2), .MAX_HOLD(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    rr_arb_4req #(.N(4), .IDW(2), .MAX_HOLD(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i,
                       input logic v, input logic p);
        vec_t t;
        t.req = r; t.gnt = g; t.id = i; t.valid = v; t.pre = p;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] i,
                           input logic v, input logic p);
        check({tag, ".gnt"},     32'(bus_a.gnt), 32'(g));
        check({tag, ".gnt_id"},  32'(bus_a.gnt_id), 32'(i));
        check({tag, ".valid"},   32'(bus_a.gnt_valid), 32'(v));
        check({tag, ".preempt"}, 32'(bus_a.preempt), 32'(p));
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [1:0] exp_owner;

        // Table for MAX_HOLD=8 instance, starting from reset (ptr=0).
        add(4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b0100, 4'b0100, 2'd2, 1, 0);   // ptr -> 3
        add(4'b0100, 4'b0100, 2'd2, 1, 0);
        add(4'b0100, 4'b0100, 2'd2, 1, 0);
        add(4'b0000, 4'b0000, 2'd0, 0, 0);   // release -> idle
        add(4'b0011, 4'b0001, 2'd0, 1, 0);   // scan 3,0 -> 0, ptr -> 1
        add(4'b0011, 4'b0001, 2'd0, 1, 0);   // non-owner ignored
        add(4'b0010, 4'b0010, 2'd1, 1, 0);   // release, direct handover, ptr -> 2
        add(4'b1010, 4'b0010, 2'd1, 1, 0);
        add(4'b1000, 4'b1000, 2'd3, 1, 0);   // ptr -> 0
        add(4'b1001, 4'b1000, 2'd3, 1, 0);
        add(4'b0001, 4'b0001, 2'd0, 1, 0);   // ptr -> 1
        add(4'b1110, 4'b0010, 2'd1, 1, 0);   // release + new reqs, scan from 1
        add(4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 4'b0100, 2'd2, 1, 0);   // scan from 2, ptr -> 3
        add(4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b1011, 4'b1000, 2'd3, 1, 0);   // ptr -> 0, hold=0
        for (int k = 0; k < 7; k++) add(4'b1011, 4'b1000, 2'd3, 1, 0);   // hold 1..7
        add(4'b1011, 4'b0001, 2'd0, 1, 1);   // 8th cycle: timeout, preempt to 0
        add(4'b1011, 4'b0001, 2'd0, 1, 0);   // ptr -> 1
        add(4'b0000, 4'b0000, 2'd0, 0, 0);

        // Reset held with all requests active.
        rst_n = 1'b0;
        bus_a.req = 4'b1111;
        bus_b.req = 4'b0000;
        bus_c.req = 4'b0000;
        #1;
        check_a("reset_imm", 4'b0000, 2'd0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_a($sformatf("reset_cyc%0d", k), 4'b0000, 2'd0, 0, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            bus_a.req = vecs[k].req;
            step();
            check_a($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].id, vecs[k].valid, vecs[k].pre);
            @(negedge clk);
        end

        // MAX_HOLD=4, all requesting: owners 0,1,2,3,0 for four cycles each.
        bus_b.req = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_owner = 2'((k - 1) / 4);
            exp_g = 4'b0001 << exp_owner;
            check($sformatf("rot%0d.gnt", k), 32'(bus_b.gnt), 32'(exp_g));
            check($sformatf("rot%0d.id", k), 32'(bus_b.gnt_id), 32'(exp_owner));
            check($sformatf("rot%0d.preempt", k), 32'(bus_b.preempt),
                  32'((k > 1) && ((k - 1) % 4 == 0)));
        end
        @(negedge clk);
        bus_b.req = 4'b0000;
        step();
        check("rot_release.gnt", 32'(bus_b.gnt), 32'(4'b0000));

        // MAX_HOLD=0: owner 1 never loses the grant.
        @(negedge clk);
        bus_c.req = 4'b0010;
        step();
        check("nolimit_first.gnt", 32'(bus_c.gnt), 32'(4'b0010));
        @(negedge clk);
        bus_c.req = 4'b1111;
        for (int k = 0; k < 100; k++) begin
            step();
            check($sformatf("nolimit%0d.gnt", k), 32'(bus_c.gnt), 32'(4'b0010));
            check($sformatf("nolimit%0d.preempt", k), 32'(bus_c.preempt), 32'(1'b0));
        end

        // Asynchronous reset mid-grant; ptr of instance A is 1 here.
        @(negedge clk);
        bus_a.req = 4'b1000;
        step();
        check_a("pre_rst_grant", 4'b1000, 2'd3, 1, 0);
        step();
        check_a("pre_rst_hold", 4'b1000, 2'd3, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_a("async_rst", 4'b0000, 2'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.req = 4'b1111;
        step();
        check_a("post_rst_first", 4'b0001, 2'd0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
